yarp_lsu: RTL and testbench

Load/store unit sitting between the execute stage and the data memory port of the yarp RV32I core. It takes the ALU result as the effective data address, plus the decoded memory control, and drives a req/gnt/rvalid data-memory interface. It generates byte enables and write-lane data for stores, and aligns and extends load data. The pipeline is stalled via `lsu_busy_o` until the access completes.

---
 rtl/yarp_lsu.sv | 160 ++++++++++++++++
 tb/tb_yarp_lsu.sv | 289 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/yarp_lsu.sv
// yarp RV32I load/store unit: req/gnt/rvalid data-memory master with store lane
// steering and load alignment/extension. Optional misalignment trap: YARP_LSU_MISALIGN_CHK_EN.
module yarp_lsu (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        ex_valid_i,
  input  logic [31:0] data_addr_i,
  input  logic [31:0] data_wr_i,
  input  logic        mem_rd_i,
  input  logic        mem_wr_i,
  input  logic [1:0]  mem_size_i,
  input  logic        mem_zero_extnd_i,
  output logic        lsu_busy_o,
  output logic        lsu_done_o,
  output logic [31:0] rd_data_o,
  output logic        misalign_o,
  output logic        dmem_req_o,
  input  logic        dmem_gnt_i,
  output logic [31:0] dmem_addr_o,
  output logic        dmem_we_o,
  output logic [3:0]  dmem_be_o,
  output logic [31:0] dmem_wdata_o,
  input  logic        dmem_rvalid_i,
  input  logic [31:0] dmem_rdata_i
);

  typedef enum logic [1:0] {S_IDLE, S_REQ, S_WAIT, S_DONE} state_t;

  state_t      state, state_nxt;
  logic        accept;
  logic        misalign_nxt;
  logic [3:0]  be_nxt;
  logic [31:0] wdata_nxt;
  logic [31:0] load_data;
  logic [7:0]  load_byte;
  logic [15:0] load_half;

  logic [31:0] addr_q;
  logic [1:0]  size_q;
  logic        zext_q;
  logic        we_q;
  logic [3:0]  be_q;
  logic [31:0] wdata_q;
  logic [31:0] rd_data_q;

  assign accept = ex_valid_i & (mem_rd_i | mem_wr_i);

`ifdef YARP_LSU_MISALIGN_CHK_EN
  logic misalign_q;
  // Half needs addr[0]==0; word (size 10 or 11) needs addr[1:0]==0.
  assign misalign_nxt = ((mem_size_i == 2'b01) & data_addr_i[0]) |
                        (mem_size_i[1] & (|data_addr_i[1:0]));
`else
  assign misalign_nxt = 1'b0;
`endif

  // Store lane steering, computed from the live execute inputs at acceptance.
  always_comb begin
    // NOTE: every always_comb output gets a default first so no path can infer a latch.
    be_nxt    = 4'b1111;
    wdata_nxt = data_wr_i;
    case (mem_size_i)
      2'b00: begin
        be_nxt    = 4'b0001 << data_addr_i[1:0];
        wdata_nxt = {4{data_wr_i[7:0]}};
      end
      2'b01: begin
        be_nxt    = 4'b0011 << {data_addr_i[1], 1'b0};
        wdata_nxt = {2{data_wr_i[15:0]}};
      end
      default: ;
    endcase
  end

  // Load alignment and extension use the registered offset/size/extend flag.
  always_comb begin
    load_byte = dmem_rdata_i[{addr_q[1:0], 3'b000} +: 8];
    load_half = dmem_rdata_i[{addr_q[1], 4'b0000} +: 16];
    load_data = dmem_rdata_i;
    case (size_q)
      2'b00:   load_data = {{24{~zext_q & load_byte[7]}}, load_byte};
      2'b01:   load_data = {{16{~zext_q & load_half[15]}}, load_half};
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) state <= S_IDLE;
    else          state <= state_nxt;
  end

  always_comb begin
    state_nxt  = state;
    lsu_busy_o = 1'b0;
    case (state)
      S_IDLE: begin
        if (accept) begin
          lsu_busy_o = 1'b1;
          state_nxt  = misalign_nxt ? S_DONE : S_REQ;
        end
      end
      S_REQ: begin
        lsu_busy_o = 1'b1;
        if (dmem_gnt_i) state_nxt = we_q ? S_DONE : S_WAIT;
      end
      S_WAIT: begin
        // rvalid is only honoured here, so one arriving in the grant cycle is dropped.
        lsu_busy_o = 1'b1;
        if (dmem_rvalid_i) state_nxt = S_DONE;
      end
      S_DONE:  state_nxt = S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    // NOTE: these are plain registers, not a memory array, so all are reset to give zero outputs.
    if (!reset_n) begin
      addr_q    <= '0;
      size_q    <= '0;
      zext_q    <= 1'b0;
      we_q      <= 1'b0;
      be_q      <= '0;
      wdata_q   <= '0;
      rd_data_q <= '0;
`ifdef YARP_LSU_MISALIGN_CHK_EN
      misalign_q <= 1'b0;
`endif
    end else begin
      // NOTE: non-blocking assignments so every register samples pre-edge values.
      if ((state == S_IDLE) && accept) begin
        addr_q  <= data_addr_i;
        size_q  <= mem_size_i;
        zext_q  <= mem_zero_extnd_i;
        we_q    <= mem_wr_i;
        be_q    <= be_nxt;
        wdata_q <= wdata_nxt;
`ifdef YARP_LSU_MISALIGN_CHK_EN
        misalign_q <= misalign_nxt;
`endif
      end
      if ((state == S_WAIT) && dmem_rvalid_i) rd_data_q <= load_data;
    end
  end

  assign lsu_done_o   = (state == S_DONE);
  assign dmem_req_o   = (state == S_REQ);
  assign dmem_addr_o  = {addr_q[31:2], 2'b00};
  assign dmem_we_o    = we_q;
  assign dmem_be_o    = be_q;
  assign dmem_wdata_o = wdata_q;
  assign rd_data_o    = rd_data_q;

`ifdef YARP_LSU_MISALIGN_CHK_EN
  assign misalign_o = lsu_done_o & misalign_q;
`else
  assign misalign_o = 1'b0;
`endif

endmodule

// File: tb/tb_yarp_lsu.sv
// Scoreboard bench for yarp_lsu: byte-level memory reference model, randomized
// accesses with random grant/rvalid delays, plus directed boundary cases.
module tb_yarp_lsu;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic        ex_valid_i = 1'b0;
  logic [31:0] data_addr_i = '0;
  logic [31:0] data_wr_i = '0;
  logic        mem_rd_i = 1'b0;
  logic        mem_wr_i = 1'b0;
  logic [1:0]  mem_size_i = '0;
  logic        mem_zero_extnd_i = 1'b0;
  logic        lsu_busy_o, lsu_done_o, misalign_o;
  logic [31:0] rd_data_o;
  logic        dmem_req_o, dmem_we_o;
  logic        dmem_gnt_i = 1'b0;
  logic [31:0] dmem_addr_o, dmem_wdata_o;
  logic [3:0]  dmem_be_o;
  logic        dmem_rvalid_i = 1'b0;
  logic [31:0] dmem_rdata_i = '0;

  always #5 clk = ~clk;

  yarp_lsu dut (
    .clk(clk), .reset_n(reset_n), .ex_valid_i(ex_valid_i),
    .data_addr_i(data_addr_i), .data_wr_i(data_wr_i),
    .mem_rd_i(mem_rd_i), .mem_wr_i(mem_wr_i), .mem_size_i(mem_size_i),
    .mem_zero_extnd_i(mem_zero_extnd_i), .lsu_busy_o(lsu_busy_o),
    .lsu_done_o(lsu_done_o), .rd_data_o(rd_data_o), .misalign_o(misalign_o),
    .dmem_req_o(dmem_req_o), .dmem_gnt_i(dmem_gnt_i), .dmem_addr_o(dmem_addr_o),
    .dmem_we_o(dmem_we_o), .dmem_be_o(dmem_be_o), .dmem_wdata_o(dmem_wdata_o),
    .dmem_rvalid_i(dmem_rvalid_i), .dmem_rdata_i(dmem_rdata_i)
  );

  typedef struct { logic [31:0] addr; logic we; logic [3:0] be; logic [31:0] wdata; } req_t;
  typedef struct { logic [31:0] rd; logic mis; } resp_t;

  req_t  req_q[$];
  resp_t resp_q[$];
  int    n_checks = 0;
  int    n_fail = 0;

  logic [31:0] mem [logic [31:0]];      // slave memory, indexed by word number
  logic [7:0]  ref_mem [logic [31:0]];  // reference memory, indexed by byte address
  logic [31:0] rd_model = '0;

  int gnt_dly = 0;
  int rv_dly = 1;
  bit spur = 1'b0;
  int rv_cnt = 0;
  int g_cnt = 0;
  bit in_req = 1'b0;
  logic [31:0] pend = '0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [31:0] init_word(input logic [31:0] wn);
    return (wn * 32'h9E37_79B1) ^ 32'h5A5A_C3C3;
  endfunction

  function automatic logic [31:0] slave_rd(input logic [31:0] wn);
    return mem.exists(wn) ? mem[wn] : init_word(wn);
  endfunction

  function automatic logic [7:0] ref_byte(input logic [31:0] a);
    if (ref_mem.exists(a)) return ref_mem[a];
    return 8'(init_word(a >> 2) >> (8 * a[1:0]));
  endfunction

  task automatic preload(input logic [31:0] a, input logic [31:0] w);
    mem[a >> 2] = w;
    for (int i = 0; i < 4; i++) ref_mem[{a[31:2], 2'b00} + 32'(i)] = 8'(w >> (8 * i));
  endtask

  // Memory slave: drives gnt/rvalid #1 after each rising edge.
  initial begin
    logic [31:0] w;
    forever begin
      @(posedge clk); #1;
      dmem_gnt_i = 1'b0; dmem_rvalid_i = 1'b0; dmem_rdata_i = $urandom;
      if (rv_cnt > 0) begin
        rv_cnt--;
        if (rv_cnt == 0) begin dmem_rvalid_i = 1'b1; dmem_rdata_i = pend; end
      end
      if (!reset_n) in_req = 1'b0;
      else if (dmem_req_o) begin
        if (!in_req) begin in_req = 1'b1; g_cnt = gnt_dly; end
        if (g_cnt == 0) begin
          dmem_gnt_i = 1'b1; in_req = 1'b0;
          if (dmem_we_o) begin
            w = slave_rd(dmem_addr_o >> 2);
            for (int i = 0; i < 4; i++) if (dmem_be_o[i]) w[8*i +: 8] = dmem_wdata_o[8*i +: 8];
            mem[dmem_addr_o >> 2] = w;
          end else begin
            pend = slave_rd(dmem_addr_o >> 2);
            rv_cnt = rv_dly;
            if (spur) begin dmem_rvalid_i = 1'b1; dmem_rdata_i = ~pend; end
          end
        end else g_cnt--;
      end
    end
  end

  // Monitor: compares memory requests and completions against the scoreboard.
  initial begin
    resp_t e;
    forever begin
      @(negedge clk);
      if (reset_n) begin
        if (dmem_req_o) begin
          if (req_q.size() == 0) check("unexpected_req", dmem_req_o, 32'd0);
          else begin
            check("req_addr", dmem_addr_o, req_q[0].addr);
            check("req_we", dmem_we_o, req_q[0].we);
            check("req_be", dmem_be_o, req_q[0].be);
            if (req_q[0].we) check("req_wdata", dmem_wdata_o, req_q[0].wdata);
            if (dmem_gnt_i) void'(req_q.pop_front());
          end
        end
        if (lsu_done_o) begin
          if (resp_q.size() == 0) check("unexpected_done", lsu_done_o, 32'd0);
          else begin
            e = resp_q.pop_front();
            check("rd_data", rd_data_o, e.rd);
            check("misalign", misalign_o, e.mis);
          end
        end
      end
    end
  end

  task automatic issue(input bit rd, input bit wr, input logic [31:0] addr, input logic [31:0] data,
                       input logic [1:0] size, input bit zext, input int gd, input int rvd, input bit sp);
    int nb, exp_lat, lat, busy_bad;
    bit mis;
    logic [31:0] base, v;
    req_t r;
    resp_t e;
    nb = (size == 2'b00) ? 1 : (size == 2'b01) ? 2 : 4;
    base = addr & ~(32'(nb) - 32'd1);
    mis = 1'b0;
`ifdef YARP_LSU_MISALIGN_CHK_EN
    mis = (base != addr);
`endif
    if (!mis) begin
      r.addr = {addr[31:2], 2'b00};
      r.we = wr;
      r.be = '0;
      for (int i = 0; i < nb; i++) r.be[int'(base[1:0]) + i] = 1'b1;
      r.wdata = (nb == 1) ? {4{data[7:0]}} : (nb == 2) ? {2{data[15:0]}} : data;
      req_q.push_back(r);
      if (wr) begin
        for (int i = 0; i < nb; i++) ref_mem[base + 32'(i)] = 8'(data >> (8 * i));
      end else begin
        v = '0;
        for (int i = 0; i < nb; i++) v[8*i +: 8] = ref_byte(base + 32'(i));
        if (!zext && nb < 4 && v[8*nb-1]) v = v | ~((32'd1 << (8 * nb)) - 32'd1);
        rd_model = v;
      end
    end
    e.rd = rd_model;
    e.mis = mis;
    resp_q.push_back(e);
    exp_lat = mis ? 1 : (wr ? 2 + gd : 2 + gd + rvd);
    gnt_dly = gd; rv_dly = rvd; spur = sp;

    @(negedge clk);
    check("done_pulse_len", lsu_done_o, 32'd0);
    ex_valid_i = 1'b1; data_addr_i = addr; data_wr_i = data;
    mem_rd_i = rd; mem_wr_i = wr; mem_size_i = size; mem_zero_extnd_i = zext;
    #1 check("busy_accept", lsu_busy_o, 32'd1);
    @(posedge clk); #1;
    // Scramble the execute inputs: the LSU must not re-sample them.
    ex_valid_i = 1'b0; data_addr_i = $urandom; data_wr_i = $urandom;
    mem_size_i = 2'($urandom); mem_zero_extnd_i = 1'($urandom);

    lat = 1; busy_bad = 0;
    @(negedge clk);
    while (!lsu_done_o && lat < 64) begin
      if (!lsu_busy_o) busy_bad++;
      @(negedge clk);
      lat++;
    end
    check("latency", lat, exp_lat);
    check("busy_until_done", busy_bad, 32'd0);
    check("busy_in_done", lsu_busy_o, 32'd0);
    mem_rd_i = 1'b0; mem_wr_i = 1'b0;
  endtask

  task automatic idle_cycle();
    @(negedge clk);
    ex_valid_i = 1'b0; mem_rd_i = 1'b1;
    #1 check("busy_no_valid", lsu_busy_o, 32'd0);
    @(posedge clk); #1 mem_rd_i = 1'b0;
  endtask

  task automatic check_outputs_zero(input string tag);
    check({tag, "_busy"}, lsu_busy_o, 32'd0);
    check({tag, "_done"}, lsu_done_o, 32'd0);
    check({tag, "_rd_data"}, rd_data_o, 32'd0);
    check({tag, "_misalign"}, misalign_o, 32'd0);
    check({tag, "_req"}, dmem_req_o, 32'd0);
    check({tag, "_addr"}, dmem_addr_o, 32'd0);
    check({tag, "_we"}, dmem_we_o, 32'd0);
    check({tag, "_be"}, dmem_be_o, 32'd0);
    check({tag, "_wdata"}, dmem_wdata_o, 32'd0);
  endtask

  task automatic reset_mid_load(input logic [31:0] addr);
    req_t r;
    r.addr = {addr[31:2], 2'b00}; r.we = 1'b0; r.be = 4'b1111; r.wdata = '0;
    req_q.push_back(r);
    gnt_dly = 0; rv_dly = 8; spur = 1'b0;
    @(negedge clk);
    ex_valid_i = 1'b1; data_addr_i = addr; mem_rd_i = 1'b1; mem_wr_i = 1'b0; mem_size_i = 2'b10;
    @(posedge clk); #1 ex_valid_i = 1'b0; mem_rd_i = 1'b0;
    @(posedge clk); #3;
    reset_n = 1'b0;
    rv_cnt = 0; in_req = 1'b0; rd_model = '0;
    #1 check_outputs_zero("mid_reset");
    @(negedge clk); @(negedge clk);
    reset_n = 1'b1;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    bit rd, wr;
    #2 check_outputs_zero("por");
    repeat (3) @(negedge clk);
    reset_n = 1'b1;

    issue(1'b0, 1'b1, 32'h1000_0004, 32'hDEAD_BEEF, 2'b10, 1'b0, 0, 1, 1'b0);
    issue(1'b0, 1'b1, 32'h0000_0013, 32'h0000_00A5, 2'b00, 1'b0, 0, 1, 1'b0);

    preload(32'h2000_0000, 32'h1280_3456);
    issue(1'b1, 1'b0, 32'h2000_0002, 32'h0, 2'b00, 1'b0, 2, 3, 1'b0);
    check("lb_value", rd_data_o, 32'hFFFF_FF80);
    issue(1'b1, 1'b0, 32'h2000_0002, 32'h0, 2'b00, 1'b1, 2, 3, 1'b0);
    check("lbu_value", rd_data_o, 32'h0000_0080);

    preload(32'h2000_0010, 32'h8001_7FFF);
    issue(1'b1, 1'b0, 32'h2000_0012, 32'h0, 2'b01, 1'b0, 0, 1, 1'b1);
    check("lh_value", rd_data_o, 32'hFFFF_8001);

    // Store then read back over the same word; store must not touch rd_data.
    issue(1'b1, 1'b1, 32'h2000_0011, 32'h0000_00C3, 2'b00, 1'b0, 1, 1, 1'b0);
    check("store_holds_rd", rd_data_o, 32'hFFFF_8001);
    issue(1'b1, 1'b0, 32'h2000_0010, 32'h0, 2'b10, 1'b0, 0, 2, 1'b0);
    check("rmw_word", rd_data_o, 32'h8001_C3FF);

    reset_mid_load(32'h2000_0010);
    preload(32'h2000_0020, 32'h0BAD_F00D);
    issue(1'b1, 1'b0, 32'h2000_0020, 32'h0, 2'b10, 1'b0, 1, 1, 1'b0);
    check("load_after_reset", rd_data_o, 32'h0BAD_F00D);

    preload(32'h0000_0004, 32'h7654_3210);
    issue(1'b1, 1'b0, 32'h0000_0006, 32'h0, 2'b10, 1'b0, 0, 1, 1'b0);

    for (int n = 0; n < 300; n++) begin
      if ($urandom_range(0, 9) == 0) idle_cycle();
      case ($urandom_range(0, 9))
        0:             begin rd = 1'b1; wr = 1'b1; end
        1, 2, 3, 4:    begin rd = 1'b0; wr = 1'b1; end
        default:       begin rd = 1'b1; wr = 1'b0; end
      endcase
      issue(rd, wr, 32'h3000_0000 | 32'($urandom_range(0, 31)), $urandom, 2'($urandom),
            1'($urandom), $urandom_range(0, 3), $urandom_range(1, 3), 1'($urandom));
    end

    repeat (4) @(negedge clk);
    check("req_q_drained", req_q.size(), 32'd0);
    check("resp_q_drained", resp_q.size(), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
